// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit, WIDTH-generic. It produces
//            one result bit per cycle. Valid/ready handshakes on both sides
//            let the execute stage stall on in_ready and out_valid.
// Ports    : Clock     - single clock, all state on the rising edge
//            Reset     - synchronous, active-high; clears all state and Out
//            Kill      - pipeline flush, aborts any operation in flight
//            in_valid  - request valid
//            in_ready  - unit idle and not being flushed
//            funct     - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                        100 DIV, 101 DIVU, 110 REM,    111 REMU
//            A, B      - rs1/dividend/multiplicand, rs2/divisor/multiplier
//            out_valid - result valid, held until out_ready
//            out_ready - consumer accepts result
//            Out       - result
// Config   : MULDIV_EARLY_OUT_EN - when defined, divide-by-zero, signed
//            overflow and multiply-by-zero finish straight from PREP
//            (out_valid in cycle 2). Results are identical either way.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Kill,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_PREP = 3'd1;
    localparam logic [2:0] c_ST_CALC = 3'd2;
    localparam logic [2:0] c_ST_FIX  = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(1);
    localparam logic [WIDTH-1:0] c_MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2:0]         r_state;
    logic [2:0]         r_funct;
    logic [WIDTH-1:0]   r_a;            // raw A until PREP, then |A|
    logic [WIDTH-1:0]   r_b;            // raw B until PREP, then |B|
    logic [2*WIDTH-1:0] r_acc;          // mul: product/multiplier, div: rem/quotient
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_res;      // negate product or quotient in FIX
    logic               r_neg_rem;      // negate remainder in FIX
    logic               r_special;      // architectural corner case detected
    logic [WIDTH-1:0]   r_special_val;
    logic [WIDTH-1:0]   r_out;
    logic               r_out_valid;

    // ------------------------------------------------------------------
    // Operand decode (valid while in PREP, when r_a/r_b still hold raw A/B)
    // ------------------------------------------------------------------
    logic               w_is_div;
    logic               w_signed_a;
    logic               w_signed_b;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_mul_zero;
    logic               w_special;
    logic [WIDTH-1:0]   w_special_val;

    assign w_is_div   = r_funct[2];
    assign w_signed_a = w_is_div ? ~r_funct[0] : (r_funct[1:0] != 2'b11);
    assign w_signed_b = w_is_div ? ~r_funct[0] : ~r_funct[1];
    assign w_sa       = w_signed_a & r_a[WIDTH-1];
    assign w_sb       = w_signed_b & r_b[WIDTH-1];
    assign w_mag_a    = w_sa ? -r_a : r_a;
    assign w_mag_b    = w_sb ? -r_b : r_b;

    assign w_div_zero = w_is_div & (r_b == '0);
    assign w_ovf      = w_is_div & ~r_funct[0] & (r_a == c_MIN_INT) & (&r_b);
    assign w_mul_zero = ~w_is_div & ((r_a == '0) | (r_b == '0));
    assign w_special  = w_div_zero | w_ovf | w_mul_zero;

    // funct[1] separates remainder from quotient for the divide opcodes.
    always_comb begin
        w_special_val = '0;
        if (w_div_zero) begin
            w_special_val = r_funct[1] ? r_a : '1;
        end else if (w_ovf) begin
            w_special_val = r_funct[1] ? '0 : r_a;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    // Shift-add multiply: the multiplier sits in the low half and is
    // consumed LSB first while partial sums enter from the top.
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                        (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};

    // Restoring divide: the dividend shifts out of the low half into a
    // WIDTH+1 bit trial remainder, quotient bits shift in at the bottom.
    // When the trial is >= divisor the true difference fits WIDTH bits.
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_trial    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge       = (w_trial >= {1'b0, r_b});
    assign w_sub      = w_trial[WIDTH-1:0] - r_b;
    assign w_div_next = {(w_ge ? w_sub : w_trial[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

    // ------------------------------------------------------------------
    // Sign fix-up and result select
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_result;

    assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_result = w_prod_fix[WIDTH-1:0];
        case (r_funct)
            3'b000:                 w_result = w_prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_result = w_quo_fix;
            default:                w_result = w_rem_fix;
        endcase
        if (r_special) begin
            w_result = r_special_val;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state       <= c_ST_IDLE;
            r_funct       <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_neg_res     <= 1'b0;
            r_neg_rem     <= 1'b0;
            r_special     <= 1'b0;
            r_special_val <= '0;
            r_out         <= '0;
            r_out_valid   <= 1'b0;
        end else if (Kill) begin
            // Flush discards work in flight but leaves Out as it was.
            r_state     <= c_ST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_funct <= funct;
                        r_a     <= A;
                        r_b     <= B;
                        r_state <= c_ST_PREP;
                    end
                end
                c_ST_PREP: begin
                    r_a           <= w_mag_a;
                    r_b           <= w_mag_b;
                    r_acc         <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                    r_neg_res     <= w_sa ^ w_sb;
                    r_neg_rem     <= w_sa;
                    r_cnt         <= c_CNT_INIT;
                    r_special     <= w_special;
                    r_special_val <= w_special_val;
                    r_state       <= c_ST_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                    if (w_special) begin
                        r_out       <= w_special_val;
                        r_out_valid <= 1'b1;
                        r_state     <= c_ST_DONE;
                    end
`endif
                end
                c_ST_CALC: begin
                    r_acc <= w_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt - c_CNT_LAST;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_ST_FIX;
                    end
                end
                c_ST_FIX: begin
                    r_out       <= w_result;
                    r_out_valid <= 1'b1;
                    r_state     <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_ST_IDLE) && !Kill;
    assign out_valid = r_out_valid;
    assign Out       = r_out;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit: table of directed vectors
//            with hand-computed results and latencies, followed by directed
//            sequences for output hold, Kill and Reset mid-operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int WIDTH     = 32;
    localparam bit EARLY_OUT = 1'b0;   // set to 1 when MULDIV_EARLY_OUT_EN is built in
    localparam int LAT_FULL  = WIDTH + 3;
    localparam int LAT_EARLY = 2;
    localparam int NVEC      = 25;

    localparam logic [2:0] c_MUL    = 3'b000;
    localparam logic [2:0] c_MULH   = 3'b001;
    localparam logic [2:0] c_MULHSU = 3'b010;
    localparam logic [2:0] c_MULHU  = 3'b011;
    localparam logic [2:0] c_DIV    = 3'b100;
    localparam logic [2:0] c_DIVU   = 3'b101;
    localparam logic [2:0] c_REM    = 3'b110;
    localparam logic [2:0] c_REMU   = 3'b111;

    typedef struct {
        logic [2:0]       f;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
        logic             special;
    } vec_t;

    vec_t vecs [NVEC];

    logic             clk = 1'b0;
    logic             rst;
    logic             kill;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;

    int n_applied     = 0;
    int n_miscompares = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .Clock     (clk),
        .Reset     (rst),
        .Kill      (kill),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (out)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_applied++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_applied++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Present a request and let the accept edge pass; afterwards the inputs
    // are scrambled so a design that keeps sampling them is caught.
    task automatic start_op(input logic [2:0] f, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        funct    = f;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        funct    = 3'($urandom);
        a        = $urandom;
        b        = $urandom;
    endtask

    // Called in cycle 1; returns the cycle number in which out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (out_valid !== 1'b1) begin
            check_bit("out_valid timeout", out_valid, 1'b1);
            lat = -1;
        end
    endtask

    task automatic handshake();
        check_bit("in_ready low in DONE", in_ready, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_bit("out_valid after accept", out_valid, 1'b0);
        check_bit("in_ready after accept", in_ready, 1'b1);
    endtask

    initial begin
        int lat;
        int exp_lat;
        logic seen;

        vecs[0]  = '{c_MUL,    32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, 1'b0};
        vecs[1]  = '{c_MULH,   32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{c_MULHU,  32'hFFFFFFFF, 32'h00000003, 32'h00000002, 1'b0};
        vecs[3]  = '{c_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{c_MUL,    32'h80000000, 32'h80000000, 32'h00000000, 1'b0};
        vecs[5]  = '{c_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
        vecs[6]  = '{c_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[7]  = '{c_MULH,   32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{c_MULHSU, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        vecs[9]  = '{c_MULHSU, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 1'b0};
        vecs[10] = '{c_MUL,    32'h12345678, 32'h00000000, 32'h00000000, 1'b1};
        vecs[11] = '{c_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
        vecs[12] = '{c_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
        vecs[13] = '{c_DIVU,   32'h00000007, 32'h00000002, 32'h00000003, 1'b0};
        vecs[14] = '{c_REMU,   32'h00000007, 32'h00000002, 32'h00000001, 1'b0};
        vecs[15] = '{c_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0};
        vecs[16] = '{c_REM,    32'd100,      32'hFFFFFFF9, 32'h00000002, 1'b0};
        vecs[17] = '{c_DIVU,   32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 1'b0};
        vecs[18] = '{c_REMU,   32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 1'b0};
        vecs[19] = '{c_DIV,    32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1'b1};
        vecs[20] = '{c_DIVU,   32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1'b1};
        vecs[21] = '{c_REM,    32'h12345678, 32'h00000000, 32'h12345678, 1'b1};
        vecs[22] = '{c_REMU,   32'h12345678, 32'h00000000, 32'h12345678, 1'b1};
        vecs[23] = '{c_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[24] = '{c_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};

        rst       = 1'b1;
        kill      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        funct     = '0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_bit("reset out_valid", out_valid, 1'b0);
        check("reset Out", out, 32'h0);
        check_bit("reset in_ready", in_ready, 1'b1);

        // Table-driven results and latencies
        for (int i = 0; i < NVEC; i++) begin
            exp_lat = (vecs[i].special && EARLY_OUT) ? LAT_EARLY : LAT_FULL;
            start_op(vecs[i].f, vecs[i].a, vecs[i].b);
            wait_valid(lat);
            check($sformatf("vec%0d f=%b Out", i, vecs[i].f), out, vecs[i].exp);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(exp_lat));
            handshake();
        end

        // Result held while the consumer stalls; a request during DONE is ignored
        start_op(c_DIVU, 32'd7, 32'd2);
        wait_valid(lat);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_bit("hold out_valid", out_valid, 1'b1);
            check("hold Out", out, 32'd3);
            check_bit("hold in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        handshake();

        // Kill in cycle 10 of a DIV: nothing emerges and Out keeps 3
        start_op(c_DIV, 32'd100, 32'd7);
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
        end
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        #1;
        check_bit("kill in_ready", in_ready, 1'b1);
        check_bit("kill out_valid", out_valid, 1'b0);
        check("kill Out unchanged", out, 32'd3);
        seen = 1'b0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check_bit("no out_valid after kill", seen, 1'b0);

        // Kill together with in_valid in IDLE: not accepted
        funct    = c_MUL;
        a        = 32'd5;
        b        = 32'd5;
        kill     = 1'b1;
        in_valid = 1'b1;
        #1;
        check_bit("kill blocks in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        kill     = 1'b0;
        in_valid = 1'b0;
        #1;
        check_bit("no accept under kill", in_ready, 1'b1);

        start_op(c_MUL, 32'd6, 32'd7);
        wait_valid(lat);
        check("MUL 6*7 after kill", out, 32'd42);
        check("MUL 6*7 latency", 32'(lat), 32'(LAT_FULL));
        handshake();

        // Reset in cycle 20: clears Out and returns to IDLE
        start_op(c_DIVU, 32'd1000, 32'd3);
        for (int k = 0; k < 19; k++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset mid-op Out", out, 32'h0);
        check_bit("reset mid-op out_valid", out_valid, 1'b0);
        check_bit("reset mid-op in_ready", in_ready, 1'b1);

        start_op(c_REMU, 32'd1000, 32'd3);
        wait_valid(lat);
        check("REMU after reset", out, 32'd1);
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
